// File: rtl/conv_out_axis_tx.sv
// conv_out_axis_tx: output stream controller for the convolution engine.
// Buffers convolved pixels from the MAC datapath in a small FIFO and sources
// them as an AXI4-Stream master. tuser marks the first beat of a frame and
// tlast marks the end of a packet. Upstream is throttled through pix_ready.
//
// Optional build macro: CONV_TX_ROW_TLAST_EN
//   defined   -> tlast on the last column of every output row (packet per row)
//   undefined -> tlast only on the final beat of the frame (packet per frame)
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start                 arms a new frame (only honoured in IDLE)
//   pix_valid/pix_data    pixel from the datapath
//   pix_ready             FIFO can accept a pixel this cycle
//   m_axis_*              AXI4-Stream master (tdata/tvalid/tready/tlast/tuser)
//   frame_done            one-cycle pulse after the final beat transfers
//   overflow              sticky: a pixel was dropped
//   current_state         FSM state for debug (IDLE=0 RUN=1 DRAIN=2 DONE=3)
module conv_out_axis_tx #(
  parameter int unsigned IMG_WIDTH  = 224,
  parameter int unsigned IMG_HEIGHT = 224,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              m_axis_tuser,
  output logic              frame_done,
  output logic              overflow,
  output logic [1:0]        current_state
);

  localparam int unsigned OUT_W = IMG_WIDTH - 2;
  localparam int unsigned OUT_H = IMG_HEIGHT - 2;
  localparam int unsigned TOTAL = OUT_W * OUT_H;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [OCC_W-1:0] occ_q;
  logic             overflow_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic drop;
  logic last_col;
  logic last_row;
  logic last_in;
  logic tlast_raw;

  always_comb begin
    full      = (occ_q == OCC_W'(FIFO_DEPTH));
    // Ready comes only from registered state, so a same-cycle pop on a full
    // FIFO does not open a slot for a push.
    pix_ready = (state_q == StRun) && !full;
    push      = pix_valid && pix_ready;
    m_axis_tvalid = (occ_q != '0);
    pop       = m_axis_tvalid && m_axis_tready;
    drop      = pix_valid && (((state_q == StRun) && !pix_ready) || (state_q == StDrain));
    last_col  = (col_q == COL_W'(OUT_W - 1));
    last_row  = (row_q == ROW_W'(OUT_H - 1));
    last_in   = (in_cnt_q == CNT_W'(TOTAL - 1));
  end

`ifdef CONV_TX_ROW_TLAST_EN
  assign tlast_raw = last_col;
`else
  assign tlast_raw = last_col && last_row;
`endif

  // Outputs are gated by tvalid so they read zero when idle or after reset.
  always_comb begin
    m_axis_tdata  = m_axis_tvalid ? mem[rd_q] : '0;
    m_axis_tlast  = m_axis_tvalid && tlast_raw;
    m_axis_tuser  = m_axis_tvalid && (row_q == '0) && (col_q == '0);
    frame_done    = (state_q == StDone);
    overflow      = overflow_q;
    current_state = state_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (push && last_in) state_d = StDrain;
      StDrain: if (pop && last_col && last_row) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      in_cnt_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && start) begin
        in_cnt_q   <= '0;
        col_q      <= '0;
        row_q      <= '0;
        wr_q       <= '0;
        rd_q       <= '0;
        occ_q      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          wr_q     <= wr_q + PTR_W'(1);
          in_cnt_q <= in_cnt_q + CNT_W'(1);
        end
        if (pop) begin
          rd_q <= rd_q + PTR_W'(1);
          if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + ROW_W'(1);
          end else begin
            col_q <= col_q + COL_W'(1);
          end
        end
        if (push && !pop) begin
          occ_q <= occ_q + OCC_W'(1);
        end else if (pop && !push) begin
          occ_q <= occ_q - OCC_W'(1);
        end
        if (drop) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q] <= pix_data;
    end
  end

endmodule

// File: tb/tb_conv_out_axis_tx.sv
// Self-checking bench for conv_out_axis_tx (5x4 image -> 3x2 = 6 beats, depth 4).
// A queue-based model tracks the frame phase, FIFO contents and beat index;
// every cycle the DUT outputs are compared against it, and each scenario
// checks its own beat order and markers.
module tb_conv_out_axis_tx;
  localparam int unsigned IMG_WIDTH  = 5;
  localparam int unsigned IMG_HEIGHT = 4;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int OUT_W = 3;
  localparam int TOTAL = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_ready;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        frame_done;
  logic        overflow;
  logic [1:0]  current_state;

  conv_out_axis_tx #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_done   (frame_done),
    .overflow     (overflow),
    .current_state(current_state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: phase 0 idle, 1 accepting, 2 draining, 3 done.
  logic [15:0] m_q[$];
  int          m_phase = 0;
  int          m_pushed = 0;
  int          m_beat = 0;
  logic        m_ovf = 1'b0;

  // Observations of the DUT stream.
  logic [15:0] got[$];
  logic        got_user[$];
  logic        got_last[$];
  logic [15:0] sent[$];
  int          obs_fd = 0;

  logic [23:0] dut_bus;
  assign dut_bus = {pix_ready, m_axis_tvalid, m_axis_tvalid ? m_axis_tdata : 16'h0,
                    m_axis_tuser, m_axis_tlast, frame_done, overflow, current_state};

  function automatic logic exp_last(input int beat);
`ifdef CONV_TX_ROW_TLAST_EN
    return (beat % OUT_W) == OUT_W - 1;
`else
    return beat == TOTAL - 1;
`endif
  endfunction

  function automatic logic [23:0] exp_bus();
    logic        v;
    logic [15:0] d;
    logic        rdy;
    v   = (m_q.size() != 0);
    d   = v ? m_q[0] : 16'h0;
    rdy = (m_phase == 1) && (m_q.size() < FIFO_DEPTH);
    return {rdy, v, d, v && (m_beat == 0), v && exp_last(m_beat), m_phase == 3, m_ovf,
            2'(m_phase)};
  endfunction

  task automatic clear_obs();
    got.delete();
    got_user.delete();
    got_last.delete();
    sent.delete();
    obs_fd = 0;
  endtask

  // Advance one clock: record what the DUT presents, then update the model.
  task automatic tick();
    bit acc, pop, drop;
    acc  = pix_valid && (m_phase == 1) && (m_q.size() < FIFO_DEPTH);
    pop  = (m_q.size() != 0) && m_axis_tready;
    drop = pix_valid && ((m_phase == 2) || ((m_phase == 1) && !acc));
    if (m_axis_tvalid && m_axis_tready) begin
      got.push_back(m_axis_tdata);
      got_user.push_back(m_axis_tuser);
      got_last.push_back(m_axis_tlast);
    end
    if (frame_done) obs_fd++;
    @(posedge clk);
    if (!reset_n) begin
      m_q.delete();
      m_phase = 0; m_pushed = 0; m_beat = 0; m_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_q.delete();
        m_phase = 1; m_pushed = 0; m_beat = 0; m_ovf = 1'b0;
      end
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_beat++;
      end
      if (acc) begin
        m_q.push_back(pix_data);
        sent.push_back(pix_data);
        m_pushed++;
      end
      if (drop) m_ovf = 1'b1;
      case (m_phase)
        1: if (m_pushed == TOTAL) m_phase = 2;
        2: if (m_beat == TOTAL) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (dut_bus !== 24'h0 || m_axis_tdata !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_values: got %h tdata %h want 000000 tdata 0000", dut_bus,
                 m_axis_tdata);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_frame();
    int n = 0;
    clear_obs();
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      pix_valid = 1'b1;
      pix_data = 16'(i);
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL basic_bus: got %h want %h", dut_bus, exp_bus());
      end
      tick();
    end
    pix_valid = 1'b0;
    while (m_phase != 0 && n < 40) begin
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL basic_bus: got %h want %h", dut_bus, exp_bus());
      end
      tick();
      n++;
    end
    vectors++;
    if (got.size() != 6 || obs_fd != 1 || current_state !== 2'd0) begin
      miscompares++;
      $display("FAIL basic_counts: got beats %0d done %0d state %0d want 6 1 0", got.size(),
               obs_fd, current_state);
    end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 16'(i + 1) || got_user[i] !== (i == 0) || got_last[i] !== exp_last(i)) begin
        miscompares++;
        $display("FAIL basic_beat%0d: got %h user %b last %b want %h user %b last %b", i,
                 got[i], got_user[i], got_last[i], 16'(i + 1), i == 0, exp_last(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] hold;
    int n = 0;
    clear_obs();
    m_axis_tready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_data = 16'($urandom);
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL bp_fill: got %h want %h", dut_bus, exp_bus());
      end
      tick();
    end
    pix_valid = 1'b0;
    vectors++;
    if (pix_ready !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full: got ready %b ovf %b want 0 0", pix_ready, overflow);
    end
    pix_valid = 1'b1;
    pix_data = 16'($urandom);
    tick();
    pix_valid = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || dut_bus !== exp_bus()) begin
      miscompares++;
      $display("FAIL bp_overflow: got ovf %b bus %h want 1 %h", overflow, dut_bus, exp_bus());
    end
    hold = m_axis_tdata;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold || m_axis_tuser !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_stable: got v %b d %h u %b want 1 %h 1", m_axis_tvalid, m_axis_tdata,
                 m_axis_tuser, hold);
      end
    end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL bp_release: got %h want %h", dut_bus, exp_bus());
      end
      tick();
    end
    vectors++;
    if (got.size() != 4 || got[0] !== sent[0] || got[3] !== sent[3] || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_beats: got %0d beats valid %b want 4 0", got.size(), m_axis_tvalid);
    end
    // Complete the frame so the next scenario starts from IDLE.
    while (m_phase != 0 && n < 40) begin
      pix_valid = (m_phase == 1);
      pix_data = 16'($urandom);
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL bp_finish: got %h want %h", dut_bus, exp_bus());
      end
      tick();
      n++;
    end
    pix_valid = 1'b0;
    vectors++;
    if (got.size() != 6 || got[5] !== sent[5] || obs_fd != 1) begin
      miscompares++;
      $display("FAIL bp_frame: got %0d beats %0d done want 6 1", got.size(), obs_fd);
    end
  endtask

  task automatic test_concurrent();
    int k = 0;
    clear_obs();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_phase != 0 && k < 60) begin
      m_axis_tready = (k % 2 == 0);
      pix_valid = (m_pushed < TOTAL) && (m_phase == 1);
      pix_data = 16'(m_pushed + 1);
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL conc_bus: got %h want %h", dut_bus, exp_bus());
      end
      tick();
      k++;
    end
    pix_valid = 1'b0;
    m_axis_tready = 1'b1;
    vectors++;
    if (got.size() != 6 || overflow !== 1'b0 || obs_fd != 1) begin
      miscompares++;
      $display("FAIL conc_counts: got %0d beats ovf %b done %0d want 6 0 1", got.size(),
               overflow, obs_fd);
    end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 16'(i + 1)) begin
        miscompares++;
        $display("FAIL conc_order%0d: got %h want %h", i, got[i], 16'(i + 1));
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      int n = 0;
      clear_obs();
      start = 1'b1;
      tick();
      start = 1'b0;
      while (m_phase != 0 && n < 300) begin
        pix_valid = ($urandom_range(0, 99) < 60);
        pix_data = 16'($urandom);
        m_axis_tready = ($urandom_range(0, 99) < 50);
        start = ($urandom_range(0, 9) == 0);
        vectors++;
        if (dut_bus !== exp_bus()) begin
          miscompares++;
          $display("FAIL rand_bus f%0d: got %h want %h", f, dut_bus, exp_bus());
        end
        tick();
        n++;
      end
      pix_valid = 1'b0;
      start = 1'b0;
      vectors++;
      if (m_phase != 0 || got.size() != 6 || obs_fd != 1) begin
        miscompares++;
        $display("FAIL rand_frame f%0d: got %0d beats %0d done want 6 1", f, got.size(), obs_fd);
      end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
        vectors++;
        if (got[i] !== sent[i] || got_user[i] !== (i == 0) || got_last[i] !== exp_last(i)) begin
          miscompares++;
          $display("FAIL rand_beat f%0d b%0d: got %h u%b l%b want %h", f, i, got[i], got_user[i],
                   got_last[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    clear_obs();
    m_axis_tready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_data = 16'($urandom);
      tick();
    end
    pix_valid = 1'b1;
    reset_n = 1'b0;
    tick();
    pix_valid = 1'b0;
    vectors++;
    if (dut_bus !== 24'h0 || m_axis_tdata !== 16'h0) begin
      miscompares++;
      $display("FAIL midrst_values: got %h tdata %h want 000000 0000", dut_bus, m_axis_tdata);
    end
    reset_n = 1'b1;
    tick();
    clear_obs();
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_phase != 0 && n < 40) begin
      pix_valid = (m_phase == 1);
      pix_data = 16'($urandom);
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL midrst_bus: got %h want %h", dut_bus, exp_bus());
      end
      tick();
      n++;
    end
    pix_valid = 1'b0;
    vectors++;
    if (got.size() != 6 || got[0] !== sent[0] || got_user[0] !== 1'b1 || got[5] !== sent[5]) begin
      miscompares++;
      $display("FAIL midrst_frame: got %0d beats want 6 clean beats", got.size());
    end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    clear_obs();
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_phase != 0 && n < 40) begin
      pix_valid = (m_phase == 1);
      pix_data = 16'(16'h0a0 + m_pushed);
      start = (n == 2) || (n == 7);
      vectors++;
      if (dut_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL startign_bus: got %h want %h", dut_bus, exp_bus());
      end
      tick();
      n++;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    vectors++;
    if (got.size() != 6 || got[5] !== 16'h0a5 || obs_fd != 1 || current_state !== 2'd0) begin
      miscompares++;
      $display("FAIL startign_frame: got %0d beats last %h done %0d want 6 00a5 1",
               got.size(), got.size() ? got[got.size() - 1] : 16'h0, obs_fd);
    end
  endtask

  task automatic test_drain_overflow();
    int n = 0;
    clear_obs();
    m_axis_tready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (m_pushed < TOTAL && n < 40) begin
      pix_valid = 1'b1;
      pix_data = 16'($urandom);
      tick();
      n++;
    end
    m_axis_tready = 1'b0;
    pix_valid = 1'b1;
    vectors++;
    if (current_state !== 2'd2 || pix_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_state: got state %0d ready %b want 2 0", current_state, pix_ready);
    end
    tick();
    pix_valid = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || dut_bus !== exp_bus()) begin
      miscompares++;
      $display("FAIL drain_ovf: got ovf %b bus %h want 1 %h", overflow, dut_bus, exp_bus());
    end
    m_axis_tready = 1'b1;
    n = 0;
    while (m_phase != 0 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      tick();
    end
    pix_valid = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || current_state !== 2'd0 || m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore: got ovf %b state %0d valid %b want 1 0 0", overflow,
               current_state, m_axis_tvalid);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || current_state !== 2'd1 || pix_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_clears: got ovf %b state %0d ready %b want 0 1 1", overflow,
               current_state, pix_ready);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_concurrent();
    test_random_frames();
    test_mid_reset();
    test_start_ignored();
    test_drain_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
